uart_rx_frame: RTL



---
 rtl/uart_rx_frame_if.sv | 32 +++
 rtl/uart_rx_frame.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if
//   Groups the serial line and the received-byte outputs of the 8N1 receiver.
//   slave  : receiver side (takes rx, drives the byte/strobe/status signals)
//   master : line driver / consumer side
//   rx          serial line, idle high, asynchronous to clk
//   rx_data     last good byte, LSB = first data bit on the line
//   rx_valid    one-cycle pulse, rx_data holds a new good byte
//   frame_error one-cycle pulse, stop bit sampled low
//   busy        high while a frame is in progress
interface uart_rx_frame_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       busy;

  modport slave (
    input  rx,
    output rx_data,
    output rx_valid,
    output frame_error,
    output busy
  );

  modport master (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  frame_error,
    input  busy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame
//   8N1 UART receiver, LSB first. The line is synchronised by two flops and
//   every decision uses the synchronised copy only. A falling line in IDLE
//   starts a frame; the start bit is re-checked at mid-bit so short glitches
//   are dropped, then each data bit and the stop bit are sampled once at
//   mid-bit using a BAUD_DIV-cycle timebase (BAUD_DIV >= 4).
// Ports
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   rx_if  uart_rx_frame_if.slave (rx in; rx_data, rx_valid, frame_error, busy out)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for rx_s low
// START     | start bit seen, confirm it is still low at mid-bit
// DATA      | sampling 8 data bits one bit period apart
// STOP      | sampling the stop bit; good byte or framing error
// WAIT_IDLE | after a framing error, wait for the line to return high
module uart_rx_frame #(
  parameter int BAUD_DIV = 10417
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_frame_if.slave rx_if
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_error_q, frame_error_d;
  logic             rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q        <= 2'b11;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], rx_if.rx};
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          // A line already back high at mid-start-bit is treated as a glitch.
          if (!rx_s) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == FULL_M1) begin
          cnt_d              = '0;
          shift_d[bit_cnt_q] = rx_s;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end
      end

      S_STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          // Leaving at mid-stop-bit leaves half a bit to catch a start bit
          // that follows the stop bit with no idle gap.
          if (rx_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = S_WAIT_IDLE;
          end
        end
      end

      S_WAIT_IDLE: begin
        // A held-low line (break) must not restart frames and repeat errors.
        if (rx_s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_if.rx_data     = rx_data_q;
  assign rx_if.rx_valid    = rx_valid_q;
  assign rx_if.frame_error = frame_error_q;
  assign rx_if.busy        = (state_q != S_IDLE);

endmodule
